// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C serial-EEPROM master.
package i2c_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA_W,
    ST_DATA_W_ACK,
    ST_RSTART,
    ST_CTRL_R,
    ST_CTRL_R_ACK,
    ST_DATA_R,
    ST_NACK,
    ST_STOP,
    ST_DONE
  } state_e;

  // Fixed device-type nibble of the EEPROM control byte.
  localparam logic [3:0] CTRL_PREFIX = 4'b1010;

  // Bit slots per complete transaction.
  localparam int WR_SLOTS = 29;
  localparam int RD_SLOTS = 39;

  // Quarter-period phases inside one bit slot.
  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  // Control byte: device prefix, block select, read/not-write.
  function automatic logic [7:0] ctrl_byte(input logic [2:0] blk, input logic rw);
    return {CTRL_PREFIX, blk, rw};
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Divides clk into quarter-SCL phases: tick pulses on the last clk of a
// phase, phase counts 0..3 within a bit slot.
module i2c_phase_gen
  import i2c_eeprom_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  // Divider and phase counters; clear restarts a slot at phase 0.
  // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= PH_0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= PH_0;
    end else if (en) begin
      if (tick) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_eeprom_master.sv
// I2C master for single-byte writes and random reads to a 2 KB EEPROM.
// One request at a time; bus levels are decoded from state, phase and the
// shared shift register.
module i2c_eeprom_master
  import i2c_eeprom_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [10:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        scl,
  inout  wire         sda
);

  state_e      state, next_state;
  logic        tick;
  logic [1:0]  phase;
  logic        accept, slot_end, sample_pt, last_bit, sda_low;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        ack_bit, err_q, wr_q;
  logic [7:0]  rdata_q, wdata_q;
  logic [10:0] addr_q;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign slot_end  = tick && (phase == PH_3);
  assign sample_pt = tick && (phase == PH_2);
  assign last_bit  = (bit_cnt == 3'd7);

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Open-drain: only ever pull low or release.
  assign sda = sda_low ? 1'b0 : 1'bz;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase_gen (
    .clk   (clk),
    .rst   (rst),
    .en    ((state != ST_IDLE) && (state != ST_DONE)),
    .clr   (accept),
    .tick  (tick),
    .phase (phase)
  );

  // State register; reset aborts any transaction with the bus released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state and bus levels for the current slot phase.
  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    scl        = 1'b1;
    sda_low    = 1'b0;
    case (state)
      ST_START: begin
        scl     = (phase != PH_3);
        sda_low = phase[1];
      end
      ST_RSTART: begin
        scl     = (phase == PH_1) || (phase == PH_2);
        sda_low = phase[1];
      end
      ST_STOP: begin
        scl     = (phase != PH_0);
        sda_low = !phase[1];
      end
      ST_CTRL, ST_ADDR, ST_DATA_W, ST_CTRL_R: begin
        scl     = phase[1];
        sda_low = !shreg[7];
      end
      ST_CTRL_ACK, ST_ADDR_ACK, ST_DATA_W_ACK, ST_CTRL_R_ACK, ST_DATA_R, ST_NACK: begin
        scl = phase[1];
      end
      default: ;
    endcase

    if (state == ST_IDLE) begin
      if (req_valid) next_state = ST_START;
    end else if (state == ST_DONE) begin
      next_state = ST_IDLE;
    end else if (slot_end) begin
      case (state)
        ST_START:      next_state = ST_CTRL;
        ST_CTRL:       if (last_bit) next_state = ST_CTRL_ACK;
        ST_CTRL_ACK:   next_state = ack_bit ? ST_STOP : ST_ADDR;
        ST_ADDR:       if (last_bit) next_state = ST_ADDR_ACK;
        ST_ADDR_ACK:   next_state = ack_bit ? ST_STOP : (wr_q ? ST_DATA_W : ST_RSTART);
        ST_DATA_W:     if (last_bit) next_state = ST_DATA_W_ACK;
        ST_DATA_W_ACK: next_state = ST_STOP;
        ST_RSTART:     next_state = ST_CTRL_R;
        ST_CTRL_R:     if (last_bit) next_state = ST_CTRL_R_ACK;
        ST_CTRL_R_ACK: next_state = ack_bit ? ST_STOP : ST_DATA_R;
        ST_DATA_R:     if (last_bit) next_state = ST_NACK;
        ST_NACK:       next_state = ST_STOP;
        ST_STOP:       next_state = ST_DONE;
        default:       next_state = ST_IDLE;
      endcase
    end
  end

  // Request capture, byte shifter, ACK sampling and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      ack_bit <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_wr;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      shreg   <= ctrl_byte(req_addr[10:8], 1'b0);
      bit_cnt <= '0;
      ack_bit <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      // Bus is sampled once per slot, on the last clk with scl high in phase 2.
      if (sample_pt) begin
        ack_bit <= sda;
        if (state == ST_DATA_R) shreg <= {shreg[6:0], sda};
      end
      if (slot_end) begin
        case (state)
          ST_CTRL, ST_ADDR, ST_DATA_W, ST_CTRL_R: begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_DATA_R: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) rdata_q <= shreg;
          end
          ST_CTRL_ACK: begin
            if (ack_bit) err_q <= 1'b1;
            else         shreg <= addr_q[7:0];
          end
          ST_ADDR_ACK: begin
            if (ack_bit)   err_q <= 1'b1;
            else if (wr_q) shreg <= wdata_q;
          end
          ST_DATA_W_ACK, ST_CTRL_R_ACK: begin
            if (ack_bit) err_q <= 1'b1;
          end
          ST_RSTART: shreg <= ctrl_byte(addr_q[10:8], 1'b1);
          default: ;
        endcase
      end
    end
  end

endmodule
